spi_ram_ctrl: RTL

Parametrised single-port RAM controller that sits behind the SPI slave and decodes its command/payload words. Each word selects write-address, write-data, read-address or read-data. Relative to the fixed 256×8 RAM, it adds independent address and data widths, non-power-of-two depth with out-of-range detection, and optional address auto-increment for burst transfers. Read data is returned to the SPI slave with a one-cycle `tx_valid` pulse.

---
 rtl/spi_ram_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/spi_ram_ctrl.sv
// Command-decoding RAM controller behind an SPI slave: address/data words in, read data out.
// Optional address auto-increment for bursts is enabled with `define RAM_AUTO_INC_EN.
module spi_ram_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter int MEM_DEPTH = 256,
  localparam int PAYLOAD = (ADDR_SIZE > DATA_SIZE) ? ADDR_SIZE : DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PAYLOAD+1:0]   din,
  input  logic                 rx_valid,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 tx_valid,
  output logic                 err,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [ADDR_SIZE-1:0] rd_addr
);

  typedef enum logic [1:0] {
    CMD_WRITE_ADD  = 2'b00,
    CMD_WRITE_DATA = 2'b01,
    CMD_READ_ADD   = 2'b10,
    CMD_READ_DATA  = 2'b11
  } cmd_t;

  // Depth is held one bit wider than the pointers so a full 2**ADDR_SIZE depth is representable.
  localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE + 1)'(MEM_DEPTH);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_SIZE-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] r_wrAddr;
  logic [ADDR_SIZE-1:0] r_rdAddr;
  logic [DATA_SIZE-1:0] r_dout;
  logic                 r_txValid;
  logic                 r_err;

  cmd_t                 w_cmd;
  logic [ADDR_SIZE-1:0] w_addrPay;
  logic [DATA_SIZE-1:0] w_dataPay;
  logic                 w_wrInRange;
  logic                 w_rdInRange;
  logic [IDX_W-1:0]     w_wrIdx;
  logic [IDX_W-1:0]     w_rdIdx;
  logic [DATA_SIZE-1:0] w_rdData;
  logic [ADDR_SIZE-1:0] w_wrNext;
  logic [ADDR_SIZE-1:0] w_rdNext;
  logic                 w_memWe;

  assign w_cmd       = cmd_t'(din[PAYLOAD+1:PAYLOAD]);
  assign w_addrPay   = din[ADDR_SIZE-1:0];
  assign w_dataPay   = din[DATA_SIZE-1:0];
  assign w_wrInRange = {1'b0, r_wrAddr} < DEPTH_W;
  assign w_rdInRange = {1'b0, r_rdAddr} < DEPTH_W;
  assign w_wrIdx     = r_wrAddr[IDX_W-1:0];
  assign w_rdIdx     = r_rdAddr[IDX_W-1:0];
  assign w_rdData    = w_rdInRange ? r_mem[w_rdIdx] : '0;
  assign w_memWe     = rst_n && rx_valid && (w_cmd == CMD_WRITE_DATA) && w_wrInRange;

`ifdef RAM_AUTO_INC_EN
  // Pointers at the last word, or already past the end, wrap back to word 0.
  assign w_wrNext = (({1'b0, r_wrAddr} + (ADDR_SIZE + 1)'(1)) >= DEPTH_W) ? '0
                  : r_wrAddr + ADDR_SIZE'(1);
  assign w_rdNext = (({1'b0, r_rdAddr} + (ADDR_SIZE + 1)'(1)) >= DEPTH_W) ? '0
                  : r_rdAddr + ADDR_SIZE'(1);
`else
  assign w_wrNext = r_wrAddr;
  assign w_rdNext = r_rdAddr;
`endif

  // Storage is deliberately left out of reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[w_wrIdx] <= w_dataPay;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrAddr  <= '0;
      r_rdAddr  <= '0;
      r_dout    <= '0;
      r_txValid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_txValid <= 1'b0;
      r_err     <= 1'b0;
      if (rx_valid) begin
        case (w_cmd)
          CMD_WRITE_ADD: r_wrAddr <= w_addrPay;
          CMD_READ_ADD:  r_rdAddr <= w_addrPay;
          CMD_WRITE_DATA: begin
            r_err    <= !w_wrInRange;
            r_wrAddr <= w_wrNext;
          end
          CMD_READ_DATA: begin
            r_dout    <= w_rdData;
            r_txValid <= 1'b1;
            r_err     <= !w_rdInRange;
            r_rdAddr  <= w_rdNext;
          end
          default: ;
        endcase
      end
    end
  end

  assign dout     = r_dout;
  assign tx_valid = r_txValid;
  assign err      = r_err;
  assign wr_addr  = r_wrAddr;
  assign rd_addr  = r_rdAddr;

endmodule
